// File: rtl/mem_addr_router.sv
// Routes core data-port requests to main memory, debug memory or an internal
// error responder, tracking outstanding requests so responses stay in order.
module mem_addr_router #(
  parameter logic [31:0] MAIN_BASE       = 32'h1000_0000,
  parameter logic [31:0] DBG_BASE        = 32'h2000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hBADA_DD00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [31:0] core_addr,
  input  logic        core_write_en,
  input  logic [3:0]  core_byte_en,
  input  logic [31:0] core_wdata,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        mainmem_valid,
  input  logic        mainmem_ready,
  output logic [31:0] mainmem_addr,
  output logic        mainmem_write_en,
  output logic [3:0]  mainmem_byte_en,
  output logic [31:0] mainmem_wdata,
  input  logic        mainmem_rvalid,
  input  logic [31:0] mainmem_rdata,
  output logic        dbgmem_valid,
  input  logic        dbgmem_ready,
  output logic [31:0] dbgmem_addr,
  output logic        dbgmem_write_en,
  output logic [3:0]  dbgmem_byte_en,
  output logic [31:0] dbgmem_wdata,
  input  logic        dbgmem_rvalid,
  input  logic [31:0] dbgmem_rdata
);

  localparam logic [1:0] TGT_MAIN = 2'd0;
  localparam logic [1:0] TGT_DBG  = 2'd1;
  localparam logic [1:0] TGT_UNM  = 2'd2;
  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);

  logic [1:0] sel_tgt;
  logic [1:0] tgt_q;
  logic [1:0] rsp_tgt;
  logic [2:0] count_q;
  logic       unm_rsp_q;
  logic       rst_q;
  logic       hold;
  logic       blocked;
  logic       accept;
  logic       rsp;
  logic       stall_q;

  always_comb begin
    if (core_addr >= DBG_BASE)       sel_tgt = TGT_DBG;
    else if (core_addr >= MAIN_BASE) sel_tgt = TGT_MAIN;
    else                             sel_tgt = TGT_UNM;
  end

  assign mainmem_addr     = core_addr;
  assign mainmem_write_en = core_write_en;
  assign mainmem_byte_en  = core_byte_en;
  assign mainmem_wdata    = core_wdata;
  assign dbgmem_addr      = core_addr - DBG_BASE;
  assign dbgmem_write_en  = core_write_en;
  assign dbgmem_byte_en   = core_byte_en;
  assign dbgmem_wdata     = core_wdata;

  // The handshake is held off during reset and for one cycle after it.
  assign hold    = rst | rst_q;
  assign blocked = (count_q == MAX_CNT) || ((count_q != 3'd0) && (sel_tgt != tgt_q));

  always_comb begin
    mainmem_valid = 1'b0;
    dbgmem_valid  = 1'b0;
    core_ready    = 1'b0;
    if (!hold && !blocked) begin
      case (sel_tgt)
        TGT_MAIN: begin
          mainmem_valid = core_valid;
          core_ready    = mainmem_ready;
        end
        TGT_DBG: begin
          dbgmem_valid = core_valid;
          core_ready   = dbgmem_ready;
        end
        default: core_ready = 1'b1;
      endcase
    end
  end

  assign accept = core_valid & core_ready;

  // With nothing outstanding, a same-cycle response belongs to the request
  // being accepted right now.
  assign rsp_tgt = (count_q == 3'd0) ? sel_tgt : tgt_q;

  always_comb begin
    rsp        = 1'b0;
    core_rdata = 32'd0;
    if (!hold) begin
      case (rsp_tgt)
        TGT_MAIN: core_rdata = mainmem_rdata;
        TGT_DBG:  core_rdata = dbgmem_rdata;
        default:  core_rdata = ERR_RDATA;
      endcase
      if ((count_q != 3'd0) || accept) begin
        case (rsp_tgt)
          TGT_MAIN: rsp = mainmem_rvalid;
          TGT_DBG:  rsp = dbgmem_rvalid;
          default:  rsp = unm_rsp_q && (count_q != 3'd0);
        endcase
      end
    end
  end

  assign core_rvalid = rsp;
  assign core_err    = rsp && (rsp_tgt == TGT_UNM);

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      count_q   <= 3'd0;
      tgt_q     <= TGT_MAIN;
      unm_rsp_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      if (accept) tgt_q <= sel_tgt;
      count_q   <= count_q + {2'b00, accept} - {2'b00, rsp};
      unm_rsp_q <= accept && (sel_tgt == TGT_UNM);
      stall_q   <= core_valid && !core_ready && !blocked && !hold;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(accept && !rsp && (count_q == MAX_CNT)));
      assert (!(rsp && !accept && (count_q == 3'd0)));
      if (stall_q) assert (core_valid);
    end
  end
`endif

endmodule

// File: tb/tb_mem_addr_router.sv
// Directed bench for mem_addr_router: decode, blocking, ordering, the error
// responder, zero-latency responses and reset behaviour.
module tb_mem_addr_router;

  logic        clk;
  logic        rst;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_addr;
  logic        core_write_en;
  logic [3:0]  core_byte_en;
  logic [31:0] core_wdata;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        mainmem_valid;
  logic        mainmem_ready;
  logic [31:0] mainmem_addr;
  logic        mainmem_write_en;
  logic [3:0]  mainmem_byte_en;
  logic [31:0] mainmem_wdata;
  logic        mainmem_rvalid;
  logic [31:0] mainmem_rdata;
  logic        dbgmem_valid;
  logic        dbgmem_ready;
  logic [31:0] dbgmem_addr;
  logic        dbgmem_write_en;
  logic [3:0]  dbgmem_byte_en;
  logic [31:0] dbgmem_wdata;
  logic        dbgmem_rvalid;
  logic [31:0] dbgmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_addr_router dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
    .core_write_en(core_write_en), .core_byte_en(core_byte_en), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .mainmem_valid(mainmem_valid), .mainmem_ready(mainmem_ready), .mainmem_addr(mainmem_addr),
    .mainmem_write_en(mainmem_write_en), .mainmem_byte_en(mainmem_byte_en),
    .mainmem_wdata(mainmem_wdata), .mainmem_rvalid(mainmem_rvalid), .mainmem_rdata(mainmem_rdata),
    .dbgmem_valid(dbgmem_valid), .dbgmem_ready(dbgmem_ready), .dbgmem_addr(dbgmem_addr),
    .dbgmem_write_en(dbgmem_write_en), .dbgmem_byte_en(dbgmem_byte_en),
    .dbgmem_wdata(dbgmem_wdata), .dbgmem_rvalid(dbgmem_rvalid), .dbgmem_rdata(dbgmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata);
    core_valid    = valid;
    core_addr     = addr;
    core_write_en = we;
    core_byte_en  = be;
    core_wdata    = wdata;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mainmem_ready = 1'b0; mainmem_rvalid = 1'b0; mainmem_rdata = 32'd0;
    dbgmem_ready  = 1'b0; dbgmem_rvalid  = 1'b0; dbgmem_rdata  = 32'd0;
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 4'hF, 32'd0);
    step();
    // Reset cycle and the cycle after: an unmapped request must not be granted
    checkOutput("rst_core_ready", 32'(core_ready), 32'd0);
    checkOutput("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    checkOutput("rst_main_valid", 32'(mainmem_valid), 32'd0);
    step();
    rst = 1'b0;
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h1111_1111;
    #2;
    checkOutput("post_rst_core_ready", 32'(core_ready), 32'd0);
    checkOutput("post_rst_core_rvalid", 32'(core_rvalid), 32'd0);
    checkOutput("post_rst_core_err", 32'(core_err), 32'd0);
    checkOutput("post_rst_core_rdata", core_rdata, 32'd0);
    checkOutput("post_rst_dbg_valid", 32'(dbgmem_valid), 32'd0);
    mainmem_rvalid = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    step();

    // MAIN read with one-cycle response
    mainmem_ready = 1'b1;
    applyStimulus(1'b1, 32'h1000_0040, 1'b0, 4'hF, 32'd0);
    checkOutput("a_main_valid", 32'(mainmem_valid), 32'd1);
    checkOutput("a_main_addr", mainmem_addr, 32'h1000_0040);
    checkOutput("a_core_ready", 32'(core_ready), 32'd1);
    checkOutput("a_dbg_valid", 32'(dbgmem_valid), 32'd0);
    step();
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h1234_5678;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("a_core_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("a_core_rdata", core_rdata, 32'h1234_5678);
    checkOutput("a_core_err", 32'(core_err), 32'd0);
    step();
    mainmem_rvalid = 1'b0;

    // DBG write, address rebased, write fields forwarded
    dbgmem_ready = 1'b1;
    applyStimulus(1'b1, 32'h2000_0104, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    checkOutput("b_dbg_valid", 32'(dbgmem_valid), 32'd1);
    checkOutput("b_dbg_addr", dbgmem_addr, 32'h0000_0104);
    checkOutput("b_dbg_be", 32'(dbgmem_byte_en), 32'h3);
    checkOutput("b_dbg_wdata", dbgmem_wdata, 32'hDEAD_BEEF);
    checkOutput("b_dbg_we", 32'(dbgmem_write_en), 32'd1);
    checkOutput("b_main_wdata", mainmem_wdata, 32'hDEAD_BEEF);
    checkOutput("b_main_valid", 32'(mainmem_valid), 32'd0);
    step();
    dbgmem_rvalid = 1'b1; dbgmem_rdata = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("b_core_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("b_main_valid2", 32'(mainmem_valid), 32'd0);
    step();
    dbgmem_rvalid = 1'b0;

    // Unmapped read answered internally on the following cycle
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 4'hF, 32'd0);
    checkOutput("c_core_ready", 32'(core_ready), 32'd1);
    checkOutput("c_main_valid", 32'(mainmem_valid), 32'd0);
    checkOutput("c_dbg_valid", 32'(dbgmem_valid), 32'd0);
    checkOutput("c_rvalid_early", 32'(core_rvalid), 32'd0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("c_core_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("c_core_rdata", core_rdata, 32'hBADA_DD00);
    checkOutput("c_core_err", 32'(core_err), 32'd1);
    step();
    checkOutput("c_single_rsp", 32'(core_rvalid), 32'd0);

    // Two MAIN reads outstanding, third blocked until a response returns
    applyStimulus(1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'd0);
    checkOutput("d_ready1", 32'(core_ready), 32'd1);
    step();
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'd0);
    checkOutput("d_ready2", 32'(core_ready), 32'd1);
    step();
    applyStimulus(1'b1, 32'h1000_0008, 1'b0, 4'hF, 32'd0);
    checkOutput("d_blocked_ready", 32'(core_ready), 32'd0);
    checkOutput("d_blocked_valid", 32'(mainmem_valid), 32'd0);
    step();
    checkOutput("d_still_blocked", 32'(core_ready), 32'd0);
    step();
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h0000_0001;
    #2;
    checkOutput("d_rsp1_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("d_rsp1_rdata", core_rdata, 32'h0000_0001);
    checkOutput("d_rsp1_blocked", 32'(core_ready), 32'd0);
    step();
    mainmem_rvalid = 1'b0;
    #2;
    checkOutput("d_third_ready", 32'(core_ready), 32'd1);
    checkOutput("d_third_valid", 32'(mainmem_valid), 32'd1);
    step();
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h0000_0002;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("d_rsp2_rdata", core_rdata, 32'h0000_0002);
    step();
    mainmem_rdata = 32'h0000_0003;
    #2;
    checkOutput("d_rsp3_rvalid", 32'(core_rvalid), 32'd1);
    step();
    mainmem_rvalid = 1'b0;
    #2;
    checkOutput("d_drained", 32'(core_rvalid), 32'd0);

    // MAIN outstanding, DBG request waits for the MAIN response
    applyStimulus(1'b1, 32'h1000_0100, 1'b0, 4'hF, 32'd0);
    step();
    applyStimulus(1'b1, 32'h2000_0008, 1'b0, 4'hF, 32'd0);
    checkOutput("e_dbg_held", 32'(dbgmem_valid), 32'd0);
    checkOutput("e_ready_held", 32'(core_ready), 32'd0);
    step();
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h0000_AAAA;
    #2;
    checkOutput("e_main_rsp", core_rdata, 32'h0000_AAAA);
    checkOutput("e_main_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("e_dbg_held2", 32'(dbgmem_valid), 32'd0);
    step();
    mainmem_rvalid = 1'b0;
    #2;
    checkOutput("e_dbg_issue", 32'(dbgmem_valid), 32'd1);
    checkOutput("e_dbg_addr", dbgmem_addr, 32'h0000_0008);
    checkOutput("e_dbg_ready", 32'(core_ready), 32'd1);
    step();
    dbgmem_rvalid = 1'b1; dbgmem_rdata = 32'h0000_BBBB;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("e_dbg_rsp", core_rdata, 32'h0000_BBBB);
    checkOutput("e_dbg_rvalid", 32'(core_rvalid), 32'd1);
    step();
    dbgmem_rvalid = 1'b0;

    // Zero-latency MAIN response, then an immediate switch to DBG
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h0000_5555;
    applyStimulus(1'b1, 32'h1000_0200, 1'b0, 4'hF, 32'd0);
    checkOutput("g_ready", 32'(core_ready), 32'd1);
    checkOutput("g_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("g_rdata", core_rdata, 32'h0000_5555);
    step();
    mainmem_rvalid = 1'b0;
    applyStimulus(1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'd0);
    checkOutput("g_switch_valid", 32'(dbgmem_valid), 32'd1);
    checkOutput("g_switch_ready", 32'(core_ready), 32'd1);
    step();
    dbgmem_rvalid = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("g_dbg_rvalid", 32'(core_rvalid), 32'd1);
    step();
    dbgmem_rvalid = 1'b0;

    // Reset with two MAIN reads outstanding; stale responses must vanish
    applyStimulus(1'b1, 32'h1000_0300, 1'b0, 4'hF, 32'd0);
    step();
    applyStimulus(1'b1, 32'h1000_0304, 1'b0, 4'hF, 32'd0);
    step();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    step();
    rst = 1'b0;
    mainmem_rvalid = 1'b1; mainmem_rdata = 32'h0000_7777;
    #2;
    checkOutput("f_stale_hold", 32'(core_rvalid), 32'd0);
    step();
    applyStimulus(1'b1, 32'h2000_0040, 1'b0, 4'hF, 32'd0);
    checkOutput("f_stale_rvalid", 32'(core_rvalid), 32'd0);
    checkOutput("f_dbg_ready", 32'(core_ready), 32'd1);
    checkOutput("f_dbg_valid", 32'(dbgmem_valid), 32'd1);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    checkOutput("f_stale_other", 32'(core_rvalid), 32'd0);
    step();
    mainmem_rvalid = 1'b0;
    dbgmem_rvalid = 1'b1; dbgmem_rdata = 32'h0000_CCCC;
    #2;
    checkOutput("f_dbg_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("f_dbg_rdata", core_rdata, 32'h0000_CCCC);
    step();
    dbgmem_rvalid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
